// File: rtl/gated_edge_counter_pkg.sv
// ---------------------------------------------------------------------------
// gated_edge_counter_pkg
//   Shared constants for the frequency-counter datapath: default clock and
//   UART rates, default gate/detect windows, count width, FSM state encoding
//   and the saturating-increment helper used by the edge counter.
// ---------------------------------------------------------------------------
package gated_edge_counter_pkg;

  // System-level defaults
  localparam int unsigned CLK_FREQ_HZ      = 25_000_000;
  localparam int unsigned BAUD_DEF         = 115_200;
  localparam int unsigned GATE_CYCLES_DEF  = CLK_FREQ_HZ;
  localparam int unsigned DET_CYCLES_DEF   = CLK_FREQ_HZ / 10;
  localparam int unsigned SYNC_STAGES_DEF  = 2;

  // Edge count word
  localparam int unsigned        COUNT_W   = 32;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  // Measurement FSM states
  typedef enum logic {
    ST_ARM  = 1'b0,
    ST_GATE = 1'b1
  } state_t;

  // Add one when inc is set, sticking at the all-ones ceiling instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v,
                                                 input logic               inc);
    return (inc && (v != COUNT_MAX)) ? (v + COUNT_W'(1)) : v;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
//   Brings an asynchronous input into the i_Clk domain through a chain of
//   SYNC_STAGES flops, keeps one more flop of history and flags the rising
//   edge of the synchronised level. Reusable for buttons and PMOD inputs.
// Ports
//   i_Clk    in  1  system clock
//   rst      in  1  synchronous active-high reset, clears chain and history
//   d_async  in  1  raw asynchronous input
//   o_level  out 1  synchronised level (last chain flop)
//   o_rise   out 1  high for one cycle when o_level goes 0 -> 1
// ---------------------------------------------------------------------------
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_Clk,
  input  logic rst,
  input  logic d_async,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Metastability chain plus one sample of history for edge detection
  always_ff @(posedge i_Clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign o_level = sync_q[SYNC_STAGES-1];

  // Decoded purely from flops, so it is glitch-free within the cycle
  assign o_rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/gated_edge_counter.sv
// ---------------------------------------------------------------------------
// gated_edge_counter
//   Measurement front end of the frequency counter. Synchronises freq_in,
//   counts its rising edges over back-to-back windows of GATE_CYCLES clocks,
//   and publishes one saturating 32-bit count per window with a single-cycle
//   strobe. A retriggerable timeout reports whether the input is toggling.
// Ports
//   i_Clk          in  1   system clock
//   rst            in  1   synchronous active-high reset
//   freq_in        in  1   asynchronous signal under measurement
//   count_out      out 32  edges counted in the last completed window
//   count_valid    out 1   one-cycle pulse when count_out is updated
//   signal_detect  out 1   an edge was seen within the last DET_CYCLES cycles
//   gate_active    out 1   high while windows are being counted
// ---------------------------------------------------------------------------
module gated_edge_counter
  import gated_edge_counter_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = CLK_FREQ_HZ,
  parameter int unsigned GATE_CYCLES = CLK_FREQ,
  parameter int unsigned DET_CYCLES  = CLK_FREQ / 10,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic               i_Clk,
  input  logic               rst,
  input  logic               freq_in,
  output logic [COUNT_W-1:0] count_out,
  output logic               count_valid,
  output logic               signal_detect,
  output logic               gate_active
);

  localparam int unsigned GATE_W = $clog2(GATE_CYCLES);
  localparam int unsigned DET_W  = $clog2(DET_CYCLES);
  localparam int unsigned ARM_W  = $clog2(SYNC_STAGES + 2);

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [DET_W-1:0]  DET_LOAD  = DET_W'(DET_CYCLES - 1);
  // Stay armed until the chain and the history flop both hold real input,
  // so a level that is already high at reset exit never looks like an edge.
  localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'(SYNC_STAGES + 1);

  state_t             state;
  logic [ARM_W-1:0]   arm_cnt;
  logic [GATE_W-1:0]  gate_cnt;
  logic [DET_W-1:0]   det_cnt;
  logic [COUNT_W-1:0] edge_cnt;
  logic               rise;
  logic               unused_level;

  // Input synchroniser and rising-edge detector
  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_Clk   (i_Clk),
    .rst     (rst),
    .d_async (freq_in),
    .o_level (unused_level),
    .o_rise  (rise)
  );

  // Arm/gate FSM with window, edge and presence counters
  always_ff @(posedge i_Clk) begin
    if (rst) begin
      state         <= ST_ARM;
      arm_cnt       <= '0;
      gate_cnt      <= '0;
      edge_cnt      <= '0;
      det_cnt       <= '0;
      count_out     <= '0;
      count_valid   <= 1'b0;
      signal_detect <= 1'b0;
      gate_active   <= 1'b0;
    end else begin
      count_valid <= 1'b0;

      case (state)
        ST_ARM: begin
          // Edges are ignored here; the detector output is not yet trustworthy
          if (arm_cnt == ARM_LAST) begin
            state       <= ST_GATE;
            gate_active <= 1'b1;
            gate_cnt    <= '0;
            edge_cnt    <= '0;
          end else begin
            arm_cnt <= arm_cnt + ARM_W'(1);
          end
        end

        ST_GATE: begin
          if (gate_cnt == GATE_LAST) begin
            // An edge on the terminal cycle closes out with this window; the
            // next window starts on the following cycle with no dead time.
            count_out   <= sat_inc(edge_cnt, rise);
            count_valid <= 1'b1;
            gate_cnt    <= '0;
            edge_cnt    <= '0;
          end else begin
            gate_cnt <= gate_cnt + GATE_W'(1);
            edge_cnt <= sat_inc(edge_cnt, rise);
          end

          // Retriggerable presence timeout; drops the cycle after it empties
          if (rise) begin
            det_cnt       <= DET_LOAD;
            signal_detect <= 1'b1;
          end else if (det_cnt != '0) begin
            det_cnt <= det_cnt - DET_W'(1);
          end else begin
            signal_detect <= 1'b0;
          end
        end

        default: begin
          state       <= ST_ARM;
          arm_cnt     <= '0;
          gate_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gated_edge_counter.sv
`timescale 1ns/1ps
// Randomised and directed bench for gated_edge_counter with a cycle-level
// behavioural model derived from sample history and window arithmetic.
module tb_gated_edge_counter;

  localparam int unsigned G = 1000;
  localparam int unsigned D = 100;
  localparam int unsigned S = 2;

  logic        i_Clk = 1'b0;
  logic        rst;
  logic        freq_in;
  logic [31:0] count_out;
  logic        count_valid;
  logic        signal_detect;
  logic        gate_active;

  gated_edge_counter #(
    .CLK_FREQ    (25_000_000),
    .GATE_CYCLES (G),
    .DET_CYCLES  (D),
    .SYNC_STAGES (S)
  ) dut (
    .i_Clk         (i_Clk),
    .rst           (rst),
    .freq_in       (freq_in),
    .count_out     (count_out),
    .count_valid   (count_valid),
    .signal_detect (signal_detect),
    .gate_active   (gate_active)
  );

  always #5 i_Clk = ~i_Clk;

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  longint r_clk = 0;
  bit     seen_rst = 1'b0;
  bit     sat_flag = 1'b0;
  bit     sd_ever  = 1'b0;

  longint strobe_t[$];
  longint strobe_v[$];

  // Stimulus controls
  int     mode   = 0;
  int     period = 2;
  bit     hold_v = 1'b0;
  longint term_t = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad < 40)
        $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic longint gate_pos();
    return (cyc - r_clk - 4) % longint'(G);
  endfunction

  // Reference model: per-clock expectation, compared just after each edge
  initial begin : model_check
    bit     samp[$];
    longint acc;
    longint last_e;
    bit     have_e;
    longint rel;
    longint e_count;
    bit     e_valid, e_sd, e_gate, edge_now;
    samp = {1'b0, 1'b0, 1'b0, 1'b0};
    acc = 0; last_e = 0; have_e = 0;
    e_count = 0; e_valid = 0; e_sd = 0; e_gate = 0;
    forever begin
      @(posedge i_Clk);
      cyc++;
      // History of synchronised samples; reset clocks load zeros
      samp.push_front(rst ? 1'b0 : freq_in);
      void'(samp.pop_back());
      e_valid = 1'b0;
      if (rst) begin
        seen_rst = 1'b1;
        r_clk = cyc;
        e_count = 0; e_sd = 0; e_gate = 0;
        acc = 0; have_e = 0;
      end else if (seen_rst) begin
        rel = cyc - r_clk;
        e_gate = (rel >= 4);
        if (rel >= 5) begin
          // A rise first sampled at clock k is counted at clock k+2
          edge_now = samp[2] && !samp[3];
          if (edge_now) begin
            if (acc < 64'hFFFF_FFFF) acc++;
            last_e = cyc;
            have_e = 1'b1;
          end
          if ((rel - 4) % longint'(G) == 0) begin
            e_valid = 1'b1;
            e_count = sat_flag ? 64'hFFFF_FFFF : acc;
            sat_flag = 1'b0;
            acc = 0;
          end
        end
        e_sd = have_e && ((cyc - last_e) < longint'(D));
      end
      #1;
      if (seen_rst) begin
        check("valid", longint'(count_valid), longint'(e_valid));
        check("count", longint'(count_out), e_count);
        check("detect", longint'(signal_detect), longint'(e_sd));
        check("gate", longint'(gate_active), longint'(e_gate));
        if (signal_detect) sd_ever = 1'b1;
        if (count_valid) begin
          strobe_t.push_back(cyc);
          strobe_v.push_back(longint'(count_out));
        end
      end
    end
  end

  // Input driver, a moment after the falling edge so controls set there apply
  initial begin : driver
    longint n;
    longint d;
    freq_in = 1'b0;
    forever begin
      @(negedge i_Clk);
      #1;
      n = cyc + 1;
      case (mode)
        0: freq_in = hold_v;
        1: freq_in = ((n % longint'(period)) < longint'(period / 2));
        2: freq_in = 1'($urandom_range(0, 1));
        default: begin
          d = n + 2 - term_t;
          freq_in = (d == -20 || d == -18 || d == -16 || d == -14 || d == -12 ||
                     d == 0 || d == 4 || d == 6 || d == 8);
        end
      endcase
    end
  end

  task automatic clear_log();
    strobe_t.delete();
    strobe_v.delete();
  endtask

  task automatic wait_strobes(input int n, input int budget, input string name);
    int k = 0;
    while (strobe_t.size() < n && k < budget) begin
      @(negedge i_Clk);
      k++;
    end
    check(name, longint'(strobe_t.size() >= n), 1);
  endtask

  task automatic wait_pos(input longint p, input string name);
    int k = 0;
    while (!(gate_active && gate_pos() == p) && k < 2 * G) begin
      @(negedge i_Clk);
      k++;
    end
    check(name, longint'(gate_active && gate_pos() == p), 1);
  endtask

  function automatic longint strobe_at(input int i);
    return (i < strobe_v.size()) ? strobe_v[i] : -1;
  endfunction

  function automatic longint time_at(input int i);
    return (i < strobe_t.size()) ? strobe_t[i] : -1;
  endfunction

  initial begin : main
    longint v;
    rst = 1'b1;
    mode = 0;
    hold_v = 1'b1;

    // Reset with input held high; no phantom edge on release
    repeat (5) @(negedge i_Clk);
    check("rst_count", longint'(count_out), 0);
    check("rst_valid", longint'(count_valid), 0);
    check("rst_detect", longint'(signal_detect), 0);
    check("rst_gate", longint'(gate_active), 0);
    rst = 1'b0;
    clear_log();
    sd_ever = 1'b0;
    wait_strobes(1, 2000, "held_wait");
    check("held_first_delay", time_at(0) - r_clk, longint'(G + S + 2));
    check("held_first_count", strobe_at(0), 0);
    check("held_no_detect", longint'(sd_ever), 0);

    // Period-10 square wave
    mode = 1; period = 10;
    clear_log();
    wait_strobes(3, 3500, "p10_wait");
    check("p10_count1", strobe_at(1), 100);
    check("p10_count2", strobe_at(2), 100);
    check("p10_spacing", time_at(2) - time_at(1), longint'(G));

    // Toggle every cycle, then period 3
    period = 2;
    clear_log();
    wait_strobes(3, 3500, "p2_wait");
    check("p2_count", strobe_at(2), 500);
    period = 3;
    clear_log();
    wait_strobes(3, 3500, "p3_wait");
    v = strobe_at(2);
    check("p3_count", longint'(v == 333 || v == 334), 1);

    // Presence timeout and re-trigger
    mode = 0; hold_v = 1'b0;
    repeat (200) @(negedge i_Clk);
    check("det_idle", longint'(signal_detect), 0);
    hold_v = 1'b1;
    @(negedge i_Clk);
    check("det_pre0", longint'(signal_detect), 0);
    @(negedge i_Clk);
    check("det_pre1", longint'(signal_detect), 0);
    @(negedge i_Clk);
    check("det_rise", longint'(signal_detect), 1);
    repeat (D - 1) @(negedge i_Clk);
    check("det_hold", longint'(signal_detect), 1);
    @(negedge i_Clk);
    check("det_fall", longint'(signal_detect), 0);

    // Edge landing on the terminal gate cycle
    hold_v = 1'b0;
    wait_pos(100, "term_align");
    term_t = cyc + longint'(G) - 100;
    clear_log();
    mode = 3;
    wait_strobes(2, 2500, "term_wait");
    check("term_close", strobe_at(0), 6);
    check("term_next", strobe_at(1), 3);

    // Random input
    mode = 2;
    repeat (3000) @(negedge i_Clk);

    // Reset in the middle of a window
    wait_pos(500, "mid_align");
    rst = 1'b1;
    @(negedge i_Clk);
    check("mid_rst_gate", longint'(gate_active), 0);
    rst = 1'b0;
    clear_log();
    wait_strobes(1, 2000, "mid_wait");
    check("mid_first_delay", time_at(0) - r_clk, longint'(G + S + 2));

    // Saturation of the edge count
    mode = 1; period = 2;
    wait_pos(100, "sat_align");
    clear_log();
    force dut.edge_cnt = 32'hFFFF_FF00;
    sat_flag = 1'b1;
    @(negedge i_Clk);
    release dut.edge_cnt;
    wait_strobes(2, 2500, "sat_wait");
    check("sat_count", strobe_at(0), 64'hFFFF_FFFF);
    check("post_sat_count", strobe_at(1), 500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
